wb_cmd_master: RTL and testbench

- Wishbone classic-cycle initiator: the master side of the bus that drives the SDRAM controller's Wishbone slave port.
- Accepts single or incrementing-burst read/write commands on a simple valid/ready command port.
- Generates protocol-clean cyc/stb/we/sel/addr/dat sequences and returns read data and completion or error status.
- Used as synthesizable traffic source in the SDRAM controller test environment and as a building block for on-chip bus masters.

---
 rtl/wb_pkg.sv | 28 ++
 rtl/wb_beat_timer.sv | 41 ++++
 rtl/wb_cmd_master.sv | 141 ++++++++++++++
 tb/tb_wb_cmd_master.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared types for the Wishbone command master:
//   state_t  - master FSM states (IDLE / BUS / FIN)
//   cmd_t    - latched command {we, addr, len, sel}
//   WB_*     - default bus geometry; WB_LANES is the byte-lane count DW/8
// ---------------------------------------------------------------------------
package wb_pkg;

  localparam int WB_AW    = 26;
  localparam int WB_DW    = 32;
  localparam int WB_LW    = 8;
  localparam int WB_LANES = WB_DW / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    FIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic                we;
    logic [WB_AW-1:0]    addr;
    logic [WB_LW-1:0]    len;
    logic [WB_LANES-1:0] sel;
  } cmd_t;

endpackage

// File: rtl/wb_beat_timer.sv
// ---------------------------------------------------------------------------
// wb_beat_timer
// Per-beat wait counter for the Wishbone master. Counts cycles that a beat
// spends on the bus without a slave response and flags expiry.
// Ports:
//   clk     - bus clock
//   rst_n   - asynchronous active-low reset
//   active  - a beat is on the bus (master in BUS)
//   clear   - slave responded this cycle (ack or err), restart for next beat
//   expire  - beat has waited TMO cycles with no response; never set if TMO=0
// ---------------------------------------------------------------------------
module wb_beat_timer #(
  parameter int TMO = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic clear,
  output logic expire
);

  // Counter holds 0..TMO-1; the first bus cycle of a beat sees 0.
  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!active || clear) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Expiry fires in the TMO-th waiting cycle, so stb stays up exactly TMO
  // cycles before the master gives up. TMO=0 disables it entirely.
  assign expire = (TMO != 0) && active && (cnt == CW'(TMO - 1));

endmodule

// File: rtl/wb_cmd_master.sv
// ---------------------------------------------------------------------------
// wb_cmd_master
// Wishbone classic-cycle initiator. Takes single/incrementing-burst commands
// on a valid/ready port and runs them on the bus, returning read data and a
// done/err completion pulse.
// Ports:
//   wb_clk_i, wb_resetn           - clock, async active-low reset
//   cmd_valid/cmd_ready           - command handshake (ready only in IDLE)
//   cmd_we/addr/len/sel           - command fields; beats = cmd_len+1
//   wr_data/wr_pop                - write data source; pop on each acked beat
//   rd_data/rd_valid              - registered read data, one pulse per beat
//   done/err                      - completion pulse, err valid with done
//   wb_cyc_o..wb_dat_o            - Wishbone master outputs
//   wb_dat_i/wb_ack_i/wb_err_i    - Wishbone slave responses
// ---------------------------------------------------------------------------
module wb_cmd_master
  import wb_pkg::*;
#(
  parameter int AW  = WB_AW,
  parameter int DW  = WB_DW,
  parameter int LW  = WB_LW,
  parameter int TMO = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_resetn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [LW-1:0]   cmd_len,
  input  logic [DW/8-1:0] cmd_sel,
  input  logic [DW-1:0]   wr_data,
  output logic            wr_pop,
  output logic [DW-1:0]   rd_data,
  output logic            rd_valid,
  output logic            done,
  output logic            err,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [DW-1:0]   wb_dat_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i
);

  state_t state, state_nxt;
  cmd_t   cmd_q;
  logic   err_q;
  logic   expire;

  logic in_bus, last_beat, ack_ok, beat_fail, accept;

  assign in_bus    = (state == BUS);
  assign last_beat = (cmd_q.len == '0);
  assign accept    = cmd_valid && (state == IDLE);
  // Slave error beats a simultaneous ack; a timeout only counts when the
  // slave has not answered in that same cycle.
  assign ack_ok    = in_bus && wb_ack_i && !wb_err_i;
  assign beat_fail = in_bus && (wb_err_i || (expire && !wb_ack_i));

  wb_beat_timer #(.TMO(TMO)) u_timer (
    .clk    (wb_clk_i),
    .rst_n  (wb_resetn),
    .active (in_bus),
    .clear  (wb_ack_i || wb_err_i),
    .expire (expire)
  );

  always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
    if (!wb_resetn) state <= IDLE;
    else            state <= state_nxt;
  end

  // Bus controls are decoded from state so cyc/stb/we/sel fall at the same
  // edge that leaves BUS, and an async reset drops them immediately.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    wb_we_o   = 1'b0;
    wb_sel_o  = '0;
    wb_dat_o  = '0;
    wr_pop    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = BUS;
      end
      BUS: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = cmd_q.we;
        wb_sel_o = cmd_q.sel;
        if (cmd_q.we) wb_dat_o = wr_data;
        wr_pop   = ack_ok && cmd_q.we;
        if (beat_fail)                state_nxt = FIN;
        else if (ack_ok && last_beat) state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch doubles as the live beat pointer: addr advances and len
  // counts down as beats are acked, so len==0 marks the final beat.
  always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
    if (!wb_resetn) begin
      cmd_q    <= '0;
      err_q    <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= ack_ok && !cmd_q.we;
      if (ack_ok && !cmd_q.we) rd_data <= wb_dat_i;
      if (accept) begin
        cmd_q.we   <= cmd_we;
        cmd_q.addr <= cmd_addr;
        cmd_q.len  <= cmd_len;
        cmd_q.sel  <= cmd_sel;
        err_q      <= 1'b0;
      end else if (beat_fail) begin
        err_q <= 1'b1;
      end else if (ack_ok && !last_beat) begin
        cmd_q.addr <= cmd_q.addr + AW'(DW / 8);
        cmd_q.len  <= cmd_q.len - LW'(1);
      end
    end
  end

  assign wb_addr_o = cmd_q.addr;
  assign err       = err_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_wb_cmd_master
// Directed bench for wb_cmd_master (TMO=15): single write, read burst, error
// mid-burst, timeout, ack/err collision, address wrap and async reset.
// ---------------------------------------------------------------------------
module tb_wb_cmd_master;

  logic        wb_clk_i = 1'b0;
  logic        wb_resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [25:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [3:0]  cmd_sel = '0;
  logic [31:0] wr_data = '0;
  logic        wr_pop;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        err;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [25:0] wb_addr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;

  int errors = 0;
  int checks = 0;
  int popCount = 0;
  int rdvCount = 0;
  int doneCount = 0;

  wb_cmd_master #(.AW(26), .DW(32), .LW(8), .TMO(15)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_resetn (wb_resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_sel   (cmd_sel),
    .wr_data   (wr_data),
    .wr_pop    (wr_pop),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .done      (done),
    .err       (err),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_addr_o (wb_addr_o),
    .wb_sel_o  (wb_sel_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i),
    .wb_err_i  (wb_err_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge wb_clk_i) begin
    if (wr_pop === 1'b1)   popCount++;
    if (rd_valid === 1'b1) rdvCount++;
    if (done === 1'b1)     doneCount++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [25:0] addr,
                               input logic [7:0] len, input logic [3:0] sel);
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_sel   = sel;
    cmd_valid = 1'b1;
  endtask

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  logic [31:0] rdVals [4];
  int p0, r0, d0;

  initial begin
    rdVals = '{32'h11, 32'h22, 32'h33, 32'h44};
    $display("[TB] start");

    // Reset values
    #2;
    checkOutput("rst_ready", cmd_ready, 1);
    checkOutput("rst_cyc", wb_cyc_o, 0);
    checkOutput("rst_stb", wb_stb_o, 0);
    checkOutput("rst_addr", wb_addr_o, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_rdv", rd_valid, 0);
    repeat (2) @(posedge wb_clk_i);
    #1 wb_resetn = 1'b1;

    // Single write, ack two cycles after stb
    p0 = popCount; d0 = doneCount;
    applyStimulus(1'b1, 26'h100, 8'd0, 4'hF);
    wr_data = 32'hDEADBEEF;
    #1 checkOutput("t1_ready", cmd_ready, 1);
    step(); cmd_valid = 1'b0; #1;
    checkOutput("t1_cyc", wb_cyc_o, 1);
    checkOutput("t1_stb", wb_stb_o, 1);
    checkOutput("t1_we", wb_we_o, 1);
    checkOutput("t1_addr", wb_addr_o, 64'h100);
    checkOutput("t1_sel", wb_sel_o, 64'hF);
    checkOutput("t1_dat", wb_dat_o, 64'hDEADBEEF);
    checkOutput("t1_busy", cmd_ready, 0);
    checkOutput("t1_nopop", wr_pop, 0);
    step(); #1;
    checkOutput("t1_wait_cyc", wb_cyc_o, 1);
    step(); wb_ack_i = 1'b1; #1;
    checkOutput("t1_pop", wr_pop, 1);
    step(); wb_ack_i = 1'b0; #1;
    checkOutput("t1_cyc_drop", wb_cyc_o, 0);
    checkOutput("t1_stb_drop", wb_stb_o, 0);
    checkOutput("t1_we_drop", wb_we_o, 0);
    checkOutput("t1_done", done, 1);
    checkOutput("t1_err", err, 0);
    step(); #1;
    checkOutput("t1_done_clr", done, 0);
    checkOutput("t1_ready_back", cmd_ready, 1);
    checkOutput("t1_pops", popCount - p0, 1);
    checkOutput("t1_dones", doneCount - d0, 1);

    // Read burst, zero-wait acks
    r0 = rdvCount; d0 = doneCount;
    applyStimulus(1'b0, 26'h200, 8'd3, 4'hF);
    step(); cmd_valid = 1'b0; wb_ack_i = 1'b1; wb_dat_i = rdVals[0]; #1;
    checkOutput("t2_cyc", wb_cyc_o, 1);
    checkOutput("t2_addr0", wb_addr_o, 64'h200);
    checkOutput("t2_we", wb_we_o, 0);
    checkOutput("t2_dat_o", wb_dat_o, 0);
    for (int i = 1; i < 4; i++) begin
      step(); wb_dat_i = rdVals[i]; #1;
      checkOutput("t2_addr", wb_addr_o, 64'h200 + 64'(4 * i));
      checkOutput("t2_rdv", rd_valid, 1);
      checkOutput("t2_rdata", rd_data, rdVals[i-1]);
      checkOutput("t2_cyc_hold", wb_cyc_o, 1);
    end
    step(); wb_ack_i = 1'b0; #1;
    checkOutput("t2_cyc_drop", wb_cyc_o, 0);
    checkOutput("t2_done", done, 1);
    checkOutput("t2_err", err, 0);
    checkOutput("t2_rdv_last", rd_valid, 1);
    checkOutput("t2_rdata_last", rd_data, 64'h44);
    step(); #1;
    checkOutput("t2_rdv_clr", rd_valid, 0);
    checkOutput("t2_rdv_count", rdvCount - r0, 4);
    checkOutput("t2_dones", doneCount - d0, 1);

    // Write burst with slave error on the second beat
    p0 = popCount;
    applyStimulus(1'b1, 26'h300, 8'd3, 4'h3);
    wr_data = 32'hA0;
    step(); cmd_valid = 1'b0; wb_ack_i = 1'b1; #1;
    checkOutput("t3_pop1", wr_pop, 1);
    checkOutput("t3_sel", wb_sel_o, 64'h3);
    step(); wb_ack_i = 1'b0; wb_err_i = 1'b1; wr_data = 32'hA1; #1;
    checkOutput("t3_nopop", wr_pop, 0);
    checkOutput("t3_addr1", wb_addr_o, 64'h304);
    step(); wb_err_i = 1'b0; #1;
    checkOutput("t3_cyc_drop", wb_cyc_o, 0);
    checkOutput("t3_stb_drop", wb_stb_o, 0);
    checkOutput("t3_done", done, 1);
    checkOutput("t3_err", err, 1);
    checkOutput("t3_pops", popCount - p0, 1);
    step(); #1;
    checkOutput("t3_ready_back", cmd_ready, 1);

    // Timeout: slave never answers
    applyStimulus(1'b0, 26'h400, 8'd0, 4'hF);
    step(); cmd_valid = 1'b0; #1;
    checkOutput("t4_cyc", wb_cyc_o, 1);
    for (int i = 2; i <= 15; i++) begin
      step(); #1;
      checkOutput("t4_cyc_wait", wb_cyc_o, 1);
    end
    step(); #1;
    checkOutput("t4_cyc_drop", wb_cyc_o, 0);
    checkOutput("t4_done", done, 1);
    checkOutput("t4_err", err, 1);
    checkOutput("t4_busy", cmd_ready, 0);
    step(); #1;
    checkOutput("t4_ready_back", cmd_ready, 1);

    // ack and err together is an error
    p0 = popCount;
    applyStimulus(1'b1, 26'h500, 8'd1, 4'hF);
    step(); cmd_valid = 1'b0; wb_ack_i = 1'b1; wb_err_i = 1'b1; #1;
    checkOutput("t5_nopop", wr_pop, 0);
    step(); wb_ack_i = 1'b0; wb_err_i = 1'b0; #1;
    checkOutput("t5_cyc_drop", wb_cyc_o, 0);
    checkOutput("t5_done", done, 1);
    checkOutput("t5_err", err, 1);
    checkOutput("t5_pops", popCount - p0, 0);
    step();

    // Address wraps modulo 2^AW
    applyStimulus(1'b1, 26'h3FFFFFC, 8'd1, 4'hF);
    step(); cmd_valid = 1'b0; wb_ack_i = 1'b1; #1;
    checkOutput("t6_addr0", wb_addr_o, 64'h3FFFFFC);
    step(); #1;
    checkOutput("t6_addr_wrap", wb_addr_o, 0);
    checkOutput("t6_cyc", wb_cyc_o, 1);
    step(); wb_ack_i = 1'b0; #1;
    checkOutput("t6_done", done, 1);
    checkOutput("t6_err", err, 0);
    step();

    // Async reset during the second beat of a read burst
    applyStimulus(1'b0, 26'h600, 8'd3, 4'hF);
    step(); cmd_valid = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h55; #1;
    step(); wb_ack_i = 1'b0; #1;
    checkOutput("t7_cyc_pre", wb_cyc_o, 1);
    checkOutput("t7_addr_pre", wb_addr_o, 64'h604);
    d0 = doneCount;
    #1 wb_resetn = 1'b0;
    #1;
    checkOutput("t7_cyc", wb_cyc_o, 0);
    checkOutput("t7_stb", wb_stb_o, 0);
    checkOutput("t7_we", wb_we_o, 0);
    checkOutput("t7_sel", wb_sel_o, 0);
    checkOutput("t7_addr", wb_addr_o, 0);
    checkOutput("t7_rdata", rd_data, 0);
    checkOutput("t7_rdv", rd_valid, 0);
    checkOutput("t7_done", done, 0);
    checkOutput("t7_err", err, 0);
    checkOutput("t7_ready", cmd_ready, 1);
    step(); step();
    wb_resetn = 1'b1;
    step(); step(); #1;
    checkOutput("t7_no_done", doneCount - d0, 0);
    checkOutput("t7_ready_after", cmd_ready, 1);
    checkOutput("t7_cyc_after", wb_cyc_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
